adau_spi_arbiter: RTL and testbench
===================================

Name: adau_spi_arbiter

Overview:
- Shares the single ADAU SPI command master between two requesters: the power-up command-list sequencer (init port) and a CPU-facing command register in the bus logic (cpu port).
- Latches one 32-bit command at a time, drives it to the SPI master over a valid/ready handshake, and returns a one-cycle acknowledge to the requester that owned the slot.
- Gives the init port exclusive access until ADAU initialisation completes; after that, the two ports are served round-robin.

Parameters:
- CMD_W, 32, command word width.
- CPU_LOCKOUT, 1, 1 = cpu requests are held off while init_done=0; 0 = cpu may arbitrate at any time.
- TIMEOUT, 1023, max cycles spent in ISSUE without spi_ready before the command is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  SoC clock.
- resetn  in  1  asynchronous active-low reset.
- init_cmd  in  CMD_W  command from init sequencer.
- init_valid  in  1  init request; held until init_ack.
- init_ack  out  1  one-cycle pulse when init_cmd is accepted by the SPI master.
- init_done  in  1  ADAU initialisation complete (level).
- cpu_cmd  in  CMD_W  command from the CPU register.
- cpu_valid  in  1  cpu request; held until cpu_ack.
- cpu_ack  out  1  one-cycle pulse when cpu_cmd is accepted.
- spi_data  out  CMD_W  command to the SPI master.
- spi_valid  out  1  spi_data valid.
- spi_ready  in  1  SPI master idle and able to accept a command (level).
- busy  out  1  high in every state except IDLE.
- owner_cpu  out  1  1 = current or last grant went to cpu.
- timeout_err  out  1  sticky; set on timeout; cleared only by reset.

Behaviour:
- Reset: all outputs are 0, state = IDLE, last-grant = cpu (so init wins the first tie). Reset takes effect immediately, including mid-transfer; spi_valid drops asynchronously.
- States: IDLE, ISSUE, HOLDOFF.
- IDLE:
  - Eligibility: init is eligible when init_valid=1. cpu is eligible when cpu_valid=1 and (CPU_LOCKOUT=0 or init_done=1).
  - One eligible requester: it is granted.
  - Both eligible: the requester not granted last time wins.
  - On grant: latch that requester's cmd into spi_data, set owner_cpu, go to ISSUE. spi_valid rises on the next clock edge, so request-to-spi_valid latency is 1 cycle.
- ISSUE:
  - spi_valid=1 and spi_data stays stable.
  - Transfer occurs on a cycle with spi_valid=1 and spi_ready=1. On that edge: spi_valid goes to 0, the owner's ack pulses for exactly 1 cycle, last-grant updates, state goes to HOLDOFF.
  - Minimum latency from request to ack is 2 cycles.
  - Requester inputs are ignored while in ISSUE; latched data is used.
- Timeout: if TIMEOUT>0 and the cycle counter in ISSUE reaches TIMEOUT without a transfer, then spi_valid goes to 0, timeout_err is set, no ack is issued, last-grant is not updated, and the state goes to HOLDOFF. The requester keeps its valid asserted and is re-arbitrated later.
- HOLDOFF: lasts exactly 1 cycle, then IDLE. This gives the SPI master time to drop spi_ready, so one command is never issued twice. No grant is made in HOLDOFF.
- Sustained throughput: at most one command per 3 cycles, further limited by spi_ready.
- init_done falling while CPU_LOCKOUT=1: a cpu command already in ISSUE completes normally; new cpu grants are blocked.
- A requester dropping valid before its ack is a protocol violation. The command is still issued once it has been latched.
- The ISSUE counter is ceil(log2(TIMEOUT+1)) bits, saturates, and clears on entry to ISSUE.

Optional Feature:
- Macro ADAU_ARB_STATS_EN.
- When defined: adds outputs init_count[15:0] and cpu_count[15:0]. Each increments on its requester's ack and wraps from 0xFFFF to 0. Both reset to 0.
- Adds output max_wait[15:0]: the largest cycle count spent in ISSUE by any completed transfer, saturating at 0xFFFF.
- When not defined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Init-only: init_done=0, spi_ready=1, init_valid with init_cmd=0x4000_1234 -> spi_valid high 1 cycle later with spi_data=0x4000_1234; init_ack one-cycle pulse 2 cycles after request; cpu_ack never pulses.
- Lockout: CPU_LOCKOUT=1, init_done=0, cpu_valid held 50 cycles -> no cpu_ack and spi_valid stays 0. Raise init_done -> cpu_cmd issued within 2 cycles.
- Round-robin: init_done=1, both valid continuously, spi_ready=1 -> acks alternate init, cpu, init, cpu. The first grant after reset goes to init. Ack-to-ack spacing is 3 cycles.
- Backpressure: spi_ready=0 for 20 cycles during ISSUE -> spi_valid and spi_data stay stable. Raise spi_ready -> exactly one transfer and one ack. HOLDOFF observed before the next spi_valid.
- Timeout: TIMEOUT=15, spi_ready held 0 -> after 15 cycles spi_valid=0, timeout_err=1, no ack. Release spi_ready -> the same requester is reissued and acked; timeout_err stays 1.
- Reset mid-ISSUE: assert resetn=0 while spi_valid=1 -> spi_valid, busy and both acks go to 0 immediately. After release the state is IDLE and the first tie goes to init.

Source files
------------

// File: rtl/adau_spi_arbiter_if.sv
// Request, SPI-master and status signals around the ADAU SPI command arbiter.
// The statistics signals exist only when ADAU_ARB_STATS_EN is defined.
interface adau_spi_arbiter_if #(
  parameter int CMD_W = 32
);
  logic [CMD_W-1:0] init_cmd;
  logic             init_valid;
  logic             init_ack;
  logic             init_done;
  logic [CMD_W-1:0] cpu_cmd;
  logic             cpu_valid;
  logic             cpu_ack;
  logic [CMD_W-1:0] spi_data;
  logic             spi_valid;
  logic             spi_ready;
  logic             busy;
  logic             owner_cpu;
  logic             timeout_err;
`ifdef ADAU_ARB_STATS_EN
  logic [15:0]      init_count;
  logic [15:0]      cpu_count;
  logic [15:0]      max_wait;

  modport slave (
    input  init_cmd, init_valid, init_done, cpu_cmd, cpu_valid, spi_ready,
    output init_ack, cpu_ack, spi_data, spi_valid, busy, owner_cpu, timeout_err,
    output init_count, cpu_count, max_wait
  );

  modport master (
    output init_cmd, init_valid, init_done, cpu_cmd, cpu_valid, spi_ready,
    input  init_ack, cpu_ack, spi_data, spi_valid, busy, owner_cpu, timeout_err,
    input  init_count, cpu_count, max_wait
  );
`else
  modport slave (
    input  init_cmd, init_valid, init_done, cpu_cmd, cpu_valid, spi_ready,
    output init_ack, cpu_ack, spi_data, spi_valid, busy, owner_cpu, timeout_err
  );

  modport master (
    output init_cmd, init_valid, init_done, cpu_cmd, cpu_valid, spi_ready,
    input  init_ack, cpu_ack, spi_data, spi_valid, busy, owner_cpu, timeout_err
  );
`endif
endinterface

// File: rtl/adau_spi_arbiter.sv
// Shares the ADAU SPI command master between the init sequencer and the CPU register.
// Define ADAU_ARB_STATS_EN to add per-port ack counters and the worst-case ISSUE wait.
module adau_spi_arbiter #(
  parameter int CMD_W       = 32,
  parameter int CPU_LOCKOUT = 1,
  parameter int TIMEOUT     = 1023
) (
  input logic               clk,
  input logic               resetn,
  adau_spi_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] CNT_ONE = (CW + 1)'(1);
  localparam logic [CW:0] TMO_LIM = (CW + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CMD_W-1:0] data_q, data_d;
  logic             owner_q, owner_d;
  logic             last_cpu_q, last_cpu_d;
  logic             terr_q, terr_d;
  logic             iack_q, iack_d;
  logic             cack_q, cack_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CW:0]      cnt_inc;
  logic             init_el;
  logic             cpu_el;
  logic             grant_cpu;
  logic             xfer;
  logic             tmo;

  always_comb begin
    init_el   = bus.init_valid;
    cpu_el    = bus.cpu_valid && ((CPU_LOCKOUT == 0) || bus.init_done);
    // On a tie the port that did not complete the previous transfer wins.
    grant_cpu = cpu_el && (!init_el || !last_cpu_q);
    cnt_inc   = {1'b0, cnt_q} + CNT_ONE;
    xfer      = (state_q == ST_ISSUE) && bus.spi_ready;
    tmo       = (state_q == ST_ISSUE) && !bus.spi_ready && (TIMEOUT > 0) && (cnt_inc >= TMO_LIM);
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    owner_d    = owner_q;
    last_cpu_d = last_cpu_q;
    terr_d     = terr_q;
    iack_d     = 1'b0;
    cack_d     = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (init_el || cpu_el) begin
          data_d  = grant_cpu ? bus.cpu_cmd : bus.init_cmd;
          owner_d = grant_cpu;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          iack_d     = !owner_q;
          cack_d     = owner_q;
          last_cpu_d = owner_q;
          state_d    = ST_HOLDOFF;
        end else if (tmo) begin
          // Abandoned command: requester keeps valid and is re-arbitrated later.
          terr_d  = 1'b1;
          state_d = ST_HOLDOFF;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_inc[CW-1:0];
        end
      end
      ST_HOLDOFF: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      owner_q    <= 1'b0;
      last_cpu_q <= 1'b1;
      terr_q     <= 1'b0;
      iack_q     <= 1'b0;
      cack_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      owner_q    <= owner_d;
      last_cpu_q <= last_cpu_d;
      terr_q     <= terr_d;
      iack_q     <= iack_d;
      cack_q     <= cack_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.spi_data    = data_q;
  assign bus.spi_valid   = (state_q == ST_ISSUE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.owner_cpu   = owner_q;
  assign bus.timeout_err = terr_q;
  assign bus.init_ack    = iack_q;
  assign bus.cpu_ack     = cack_q;

`ifdef ADAU_ARB_STATS_EN
  logic [15:0] icnt_q;
  logic [15:0] ccnt_q;
  logic [15:0] maxw_q;
  logic [31:0] wait32;
  logic [15:0] wait16;

  // Cycles spent in ISSUE including the transfer cycle itself.
  assign wait32 = 32'(cnt_inc);
  assign wait16 = (wait32 > 32'h0000_FFFF) ? 16'hFFFF : wait32[15:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      icnt_q <= '0;
      ccnt_q <= '0;
      maxw_q <= '0;
    end else if (xfer) begin
      if (owner_q) ccnt_q <= ccnt_q + 16'd1;
      else         icnt_q <= icnt_q + 16'd1;
      if (wait16 > maxw_q) maxw_q <= wait16;
    end
  end

  assign bus.init_count = icnt_q;
  assign bus.cpu_count  = ccnt_q;
  assign bus.max_wait   = maxw_q;
`endif

endmodule

// File: tb/tb_adau_spi_arbiter.sv
// Bench for adau_spi_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_adau_spi_arbiter;
  localparam int CMD_W = 32;
  localparam int TO    = 15;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adau_spi_arbiter_if #(.CMD_W(CMD_W)) bus ();
  adau_spi_arbiter_if #(.CMD_W(CMD_W)) bus_nt ();

  adau_spi_arbiter #(.CMD_W(CMD_W), .CPU_LOCKOUT(1), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  // Second instance without timeout, used for long backpressure.
  adau_spi_arbiter #(.CMD_W(CMD_W), .CPU_LOCKOUT(1), .TIMEOUT(0)) dut_nt (
    .clk(clk), .resetn(resetn), .bus(bus_nt)
  );

  assign bus_nt.init_cmd   = bus.init_cmd;
  assign bus_nt.init_valid = bus.init_valid;
  assign bus_nt.init_done  = bus.init_done;
  assign bus_nt.cpu_cmd    = bus.cpu_cmd;
  assign bus_nt.cpu_valid  = bus.cpu_valid;
  assign bus_nt.spi_ready  = bus.spi_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit               m_issue, m_hold, m_owner, m_last_cpu, m_terr, m_iack, m_cack;
  logic [CMD_W-1:0] m_data;
  int               m_wait, m_icnt, m_ccnt, m_maxw;

  task automatic model_reset();
    m_issue = 0; m_hold = 0; m_owner = 0; m_last_cpu = 1; m_terr = 0;
    m_iack = 0; m_cack = 0; m_data = '0; m_wait = 0;
    m_icnt = 0; m_ccnt = 0; m_maxw = 0;
  endtask

  task automatic model_step();
    bit ie, ce;
    m_iack = 0;
    m_cack = 0;
    if (m_issue) begin
      m_wait++;
      if (bus.spi_ready) begin
        if (m_owner) begin m_cack = 1; m_ccnt = (m_ccnt + 1) % 65536; end
        else         begin m_iack = 1; m_icnt = (m_icnt + 1) % 65536; end
        m_last_cpu = m_owner;
        if (m_wait > m_maxw) m_maxw = (m_wait > 65535) ? 65535 : m_wait;
        m_issue = 0;
        m_hold  = 1;
      end else if (TO > 0 && m_wait >= TO) begin
        m_terr  = 1;
        m_issue = 0;
        m_hold  = 1;
      end
    end else if (m_hold) begin
      m_hold = 0;
    end else begin
      ie = bus.init_valid;
      ce = bus.cpu_valid && bus.init_done;
      if (ie || ce) begin
        if (ie && ce) m_owner = !m_last_cpu;
        else          m_owner = ce;
        m_data  = m_owner ? bus.cpu_cmd : bus.init_cmd;
        m_issue = 1;
        m_wait  = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else         model_step();
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("spi_valid", bus.spi_valid, m_issue);
      if (m_issue) check("spi_data", bus.spi_data, m_data);
      check("busy", bus.busy, m_issue | m_hold);
      check("init_ack", bus.init_ack, m_iack);
      check("cpu_ack", bus.cpu_ack, m_cack);
      check("owner_cpu", bus.owner_cpu, m_owner);
      check("timeout_err", bus.timeout_err, m_terr);
`ifdef ADAU_ARB_STATS_EN
      check("init_count", bus.init_count, 16'(m_icnt));
      check("cpu_count", bus.cpu_count, 16'(m_ccnt));
      check("max_wait", bus.max_wait, 16'(m_maxw));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    tick();
    tick();
    check("rst_spi_valid", bus.spi_valid, 0);
    check("rst_spi_data", bus.spi_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_owner", bus.owner_cpu, 0);
    check("rst_terr", bus.timeout_err, 0);
    check("rst_acks", {bus.init_ack, bus.cpu_ack}, 0);
    resetn = 1'b1;
  endtask

  task automatic rand_phase(input int n, input int pready);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.init_ack) bus.init_valid = 1'b0;
      if (bus.cpu_ack)  bus.cpu_valid  = 1'b0;
      if (!bus.init_valid && $urandom_range(99) < 30) begin
        bus.init_valid = 1'b1;
        bus.init_cmd   = $urandom;
      end
      if (!bus.cpu_valid && $urandom_range(99) < 30) begin
        bus.cpu_valid = 1'b1;
        bus.cpu_cmd   = $urandom;
      end
      bus.spi_ready = ($urandom_range(99) < pready);
      if ($urandom_range(99) < 3) bus.init_done = ~bus.init_done;
    end
  endtask

  int seen, n, hi, acks;
  int who[8];
  int when[8];

  initial begin
    bus.init_cmd = '0; bus.init_valid = 0; bus.init_done = 0;
    bus.cpu_cmd = '0; bus.cpu_valid = 0; bus.spi_ready = 0;
    apply_reset();

    // Init-only
    bus.spi_ready  = 1;
    bus.init_cmd   = 32'h4000_1234;
    bus.init_valid = 1;
    tick();
    check("t1_valid", bus.spi_valid, 1);
    check("t1_data", bus.spi_data, 32'h4000_1234);
    check("t1_ack_early", bus.init_ack, 0);
    tick();
    check("t1_ack", bus.init_ack, 1);
    check("t1_cpu_ack", bus.cpu_ack, 0);
    bus.init_valid = 0;
    tick();
    check("t1_ack_pulse", bus.init_ack, 0);
    check("t1_idle", bus.busy, 0);

    // Lockout
    bus.cpu_cmd   = 32'h8000_00A5;
    bus.cpu_valid = 1;
    seen = 0;
    repeat (50) begin
      tick();
      if (bus.spi_valid || bus.cpu_ack) seen++;
    end
    check("lock_hold", seen, 0);
    bus.init_done = 1;
    tick();
    check("lock_valid", bus.spi_valid, 1);
    check("lock_data", bus.spi_data, 32'h8000_00A5);
    check("lock_owner", bus.owner_cpu, 1);
    tick();
    check("lock_ack", bus.cpu_ack, 1);
    bus.cpu_valid = 0;
    tick();
    tick();

    // Round-robin from reset
    apply_reset();
    bus.init_done = 1; bus.spi_ready = 1;
    bus.init_valid = 1; bus.cpu_valid = 1;
    n = 0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (bus.init_ack && n < 8) begin who[n] = 0; when[n] = c; n++; bus.init_cmd = $urandom; end
      if (bus.cpu_ack && n < 8)  begin who[n] = 1; when[n] = c; n++; bus.cpu_cmd = $urandom; end
    end
    check("rr_count", n, 4);
    check("rr_first_time", when[0], 2);
    for (int k = 0; k < 4; k++) check("rr_order", who[k], k % 2);
    for (int k = 1; k < 4; k++) check("rr_spacing", when[k] - when[k-1], 3);
    bus.init_valid = 0; bus.cpu_valid = 0;
    repeat (4) tick();

    // Backpressure (long stall observed on the no-timeout instance)
    bus.spi_ready  = 0;
    bus.init_cmd   = 32'h1357_9BDF;
    bus.init_valid = 1;
    tick();
    check("bp_grant", bus_nt.spi_valid, 1);
    seen = 0;
    repeat (20) begin
      tick();
      if (!bus_nt.spi_valid || bus_nt.spi_data !== 32'h1357_9BDF || bus_nt.init_ack) seen++;
    end
    check("bp_stable", seen, 0);
    bus.spi_ready = 1;
    bus.cpu_cmd   = 32'h2468_ACE0;
    bus.cpu_valid = 1;
    tick();
    check("bp_ack", bus_nt.init_ack, 1);
    check("bp_drop", bus_nt.spi_valid, 0);
    check("bp_holdoff", bus_nt.busy, 1);
    bus.init_valid = 0;
    tick();
    check("bp_gap", bus_nt.spi_valid, 0);
    check("bp_single_ack", bus_nt.init_ack, 0);
    tick();
    check("bp_next", bus_nt.spi_valid, 1);
    check("bp_next_data", bus_nt.spi_data, 32'h2468_ACE0);
    tick();
    check("bp_cpu_ack", bus_nt.cpu_ack, 1);
    bus.cpu_valid = 0;
    repeat (3) tick();

    // Timeout
    apply_reset();
    bus.init_done  = 0;
    bus.spi_ready  = 0;
    bus.init_cmd   = 32'hC0DE_0001;
    bus.init_valid = 1;
    tick();
    hi = 0; acks = 0;
    for (int c = 0; c < 40 && bus.spi_valid; c++) begin
      hi++;
      if (bus.init_ack) acks++;
      tick();
    end
    check("to_len", hi, TO);
    check("to_err", bus.timeout_err, 1);
    check("to_no_ack", acks + bus.init_ack, 0);
    bus.spi_ready = 1;
    tick();
    tick();
    check("to_reissue", bus.spi_valid, 1);
    check("to_reissue_data", bus.spi_data, 32'hC0DE_0001);
    check("to_reissue_owner", bus.owner_cpu, 0);
    tick();
    check("to_ack", bus.init_ack, 1);
    check("to_err_sticky", bus.timeout_err, 1);
    bus.init_valid = 0;
    repeat (3) tick();

    // Reset mid-ISSUE
    bus.spi_ready  = 0;
    bus.init_done  = 1;
    bus.init_cmd   = 32'hAAAA_0001;
    bus.cpu_cmd    = 32'hBBBB_0002;
    bus.init_valid = 1;
    bus.cpu_valid  = 1;
    tick();
    tick();
    check("mr_pre_valid", bus.spi_valid, 1);
    #1;
    resetn = 1'b0;
    #1;
    check("mr_valid", bus.spi_valid, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_acks", {bus.init_ack, bus.cpu_ack}, 0);
    check("mr_terr", bus.timeout_err, 0);
    tick();
    resetn = 1'b1;
    bus.spi_ready = 1;
    tick();
    check("mr_first", bus.spi_valid, 1);
    check("mr_first_data", bus.spi_data, 32'hAAAA_0001);
    check("mr_first_owner", bus.owner_cpu, 0);
    tick();
    check("mr_ack", bus.init_ack, 1);
    bus.init_valid = 0;

    // Randomized traffic
    rand_phase(3000, 70);
    rand_phase(1500, 8);
    rand_phase(1000, 90);
    bus.init_valid = 0;
    bus.cpu_valid  = 0;
    bus.spi_ready  = 1;
    repeat (25) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
